// File: rtl/rv_mem_pkg.sv
// Shared types for the Q103H memory stage: control structs, size/writeback enums, FSM states.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } t_mem_size;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } t_sel_wb;

    typedef struct packed {
        logic       valid;
        logic [3:0] alu_op;
        logic       use_imm;
    } t_exe_ctrl;

    typedef struct packed {
        logic      valid;
        logic      mem_rd;
        logic      mem_wr;
        t_mem_size mem_size;
        logic      load_unsigned;
        t_sel_wb   sel_wb;
    } t_mem_ctrl;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_GNT    = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } t_mem_state;

    // Access crosses its natural alignment boundary.
    function automatic logic is_misaligned(input t_mem_size size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_HALF: mis = addr_lo[0];
            MEM_WORD: mis = (addr_lo != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rv_mem_if.sv
// Data-memory request/response bus between the memory stage (master) and memory (slave).
interface rv_mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/rv_mem_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data and load extraction with sign/zero extension.
module rv_mem_lsu_align
    import rv_mem_pkg::*;
(
    input  t_mem_size   mem_size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rd_word[{addr_lo, 3'b000} +: 8];
    assign half_s = rd_word[{addr_lo[1], 4'b0000} +: 16];

    // Lane selection per access size; half accesses only look at addr bit 1.
    always_comb begin
        be      = 4'b0000;
        wdata   = st_data;
        ld_data = rd_word;
        case (mem_size)
            MEM_BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = load_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            MEM_HALF: begin
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{st_data[15:0]}};
                ld_data = load_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            MEM_WORD: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = rd_word;
            end
            default: begin
                be      = 4'b0000;
                wdata   = st_data;
                ld_data = rd_word;
            end
        endcase
    end

endmodule

// File: rtl/rv_mem.sv
// Memory stage: data-memory handshake FSM, stall generation and Q104H writeback register.
// Optional misaligned-access trap enabled by defining RV_MEM_MISALIGN_EN.
module rv_mem
    import rv_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  t_mem_ctrl       ctrl,
    input  logic [31:0]     alu_out_Q103H,
    input  logic [31:0]     dmem_wr_data_Q103H,
    input  logic [31:0]     pc_plus4_Q103H,
    rv_mem_if.master        dmem,
    output logic [31:0]     wb_data_Q103H,
    output logic [31:0]     wb_data_Q104H,
    output logic            mem_stall
`ifdef RV_MEM_MISALIGN_EN
    ,
    output logic            misalign_Q103H
`endif
);

    t_mem_state  state_r;
    t_mem_state  state_nxt_s;
    logic        mem_op_s;
    logic        misalign_s;
    logic        access_s;
    logic        req_s;
    logic        done_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;
    logic [31:0] wb_nxt_s;

    assign mem_op_s = ctrl.valid & (ctrl.mem_rd | ctrl.mem_wr);

`ifdef RV_MEM_MISALIGN_EN
    assign misalign_s     = mem_op_s & is_misaligned(ctrl.mem_size, alu_out_Q103H[1:0]) & ~rst;
    assign misalign_Q103H = misalign_s;
`else
    assign misalign_s = 1'b0;
`endif

    // Reset also silences the request and stall combinationally.
    assign access_s = mem_op_s & ~misalign_s & ~rst;

    rv_mem_lsu_align u_align (
        .mem_size      (ctrl.mem_size),
        .addr_lo       (alu_out_Q103H[1:0]),
        .load_unsigned (ctrl.load_unsigned),
        .st_data       (dmem_wr_data_Q103H),
        .rd_word       (dmem.rdata),
        .be            (be_s),
        .wdata         (wdata_s),
        .ld_data       (ld_data_s)
    );

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, request and completion; rvalid only counts in WAIT_RVALID.
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_WAIT_GNT: begin
                if (access_s) begin
                    req_s = 1'b1;
                    if (dmem.gnt) begin
                        if (ctrl.mem_wr) begin
                            state_nxt_s = ST_IDLE;
                            done_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_WAIT_RVALID;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT_GNT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_RVALID: begin
                if (dmem.rvalid) begin
                    state_nxt_s = ST_IDLE;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_RVALID;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign mem_stall   = access_s & ~done_s;
    assign dmem.req    = req_s;
    assign dmem.we     = req_s & ctrl.mem_wr;
    assign dmem.addr   = {alu_out_Q103H[31:2], 2'b00};
    assign dmem.be     = be_s;
    assign dmem.wdata  = wdata_s;

    assign wb_data_Q103H = (ctrl.sel_wb == WB_PC4) ? pc_plus4_Q103H : alu_out_Q103H;

    // Writeback source; a trapped misaligned access reports its address.
    always_comb begin
        wb_nxt_s = wb_data_Q103H;
        if (misalign_s) begin
            wb_nxt_s = alu_out_Q103H;
        end else if (ctrl.sel_wb == WB_MEM) begin
            wb_nxt_s = ld_data_s;
        end else begin
            wb_nxt_s = wb_data_Q103H;
        end
    end

    // Q104H writeback register, frozen while the access is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_Q104H <= 32'h0000_0000;
        end else if (!mem_stall) begin
            wb_data_Q104H <= wb_nxt_s;
        end else begin
            wb_data_Q104H <= wb_data_Q104H;
        end
    end

endmodule

// File: tb/tb_rv_mem.sv
// Randomized bench for rv_mem against a byte-arithmetic reference model of the memory stage.
module tb_rv_mem;
    import rv_mem_pkg::*;

`ifdef RV_MEM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    t_mem_ctrl   ctrl;
    logic [31:0] alu_out;
    logic [31:0] wr_data;
    logic [31:0] pc4;
    logic [31:0] wb103;
    logic [31:0] wb104;
    logic        stall;
    logic        misalign;
    logic [31:0] model_wb;
    int          n_cmp;
    int          n_err;

    rv_mem_if dmem_bus ();

    rv_mem u_dut (
        .clk                (clk),
        .rst                (rst),
        .ctrl               (ctrl),
        .alu_out_Q103H      (alu_out),
        .dmem_wr_data_Q103H (wr_data),
        .pc_plus4_Q103H     (pc4),
        .dmem               (dmem_bus),
        .wb_data_Q103H      (wb103),
        .wb_data_Q104H      (wb104),
        .mem_stall          (stall)
`ifdef RV_MEM_MISALIGN_EN
        ,
        .misalign_Q103H     (misalign)
`endif
    );

`ifndef RV_MEM_MISALIGN_EN
    assign misalign = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic t_mem_ctrl mk(input logic v, input logic rd, input logic wr,
                                     input t_mem_size s, input logic uns, input t_sel_wb sel);
        t_mem_ctrl c;
        c.valid = v; c.mem_rd = rd; c.mem_wr = wr;
        c.mem_size = s; c.load_unsigned = uns; c.sel_wb = sel;
        return c;
    endfunction

    function automatic logic exp_mis(input t_mem_size s, input logic [31:0] a);
        return MIS_EN && ((s == MEM_HALF && (a % 2) == 1) || (s == MEM_WORD && (a % 4) != 0));
    endfunction

    function automatic logic [31:0] exp_be(input t_mem_size s, input logic [31:0] a);
        if (s == MEM_BYTE) return 32'd1 << (a % 4);
        if (s == MEM_HALF) return 32'd3 << (2 * ((a % 4) / 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input t_mem_size s, input logic [31:0] d);
        if (s == MEM_BYTE) return (d % 256) * 32'h0101_0101;
        if (s == MEM_HALF) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input t_mem_size s, input logic [31:0] a,
                                             input logic [31:0] r, input logic uns);
        logic [31:0] v;
        int unsigned w;
        int unsigned sh;
        if (s == MEM_BYTE) begin w = 8; sh = 8 * (a % 4); end
        else if (s == MEM_HALF) begin w = 16; sh = 16 * ((a % 4) / 2); end
        else begin w = 32; sh = 0; end
        v = r >> sh;
        if (w < 32) begin
            v = v % (32'd1 << w);
            if (!uns && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
        end
        return v;
    endfunction

    // One Q103H instruction; gnt arrives after gnt_dly cycles, rvalid rv_dly cycles after grant.
    task automatic run_op(input t_mem_ctrl c, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] p4, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input string tag);
        logic        mem_op;
        logic        mis;
        logic [31:0] e103;
        logic [31:0] e104;
        ctrl = c; alu_out = a; wr_data = d; pc4 = p4;
        mem_op = c.valid && (c.mem_rd || c.mem_wr);
        mis    = mem_op && exp_mis(c.mem_size, a);
        e103   = (c.sel_wb == WB_PC4) ? p4 : a;
        if (mis) e104 = a;
        else if (c.sel_wb == WB_MEM) e104 = exp_load(c.mem_size, a, rdata, c.load_unsigned);
        else e104 = e103;
        if (mem_op && !mis) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                dmem_bus.gnt    = (i == gnt_dly);
                dmem_bus.rvalid = 1'($urandom_range(0, 1));
                dmem_bus.rdata  = $urandom;
                #1;
                check_val({tag, ".req"},   32'(dmem_bus.req), 32'd1);
                check_val({tag, ".we"},    32'(dmem_bus.we), 32'(c.mem_wr));
                check_val({tag, ".addr"},  dmem_bus.addr, a - (a % 4));
                check_val({tag, ".be"},    32'(dmem_bus.be), exp_be(c.mem_size, a));
                if (c.mem_wr) check_val({tag, ".wdata"}, dmem_bus.wdata, exp_wdata(c.mem_size, d));
                check_val({tag, ".stall_g"}, 32'(stall), 32'(!(c.mem_wr && i == gnt_dly)));
                if (i == 0) check_val({tag, ".wb103"}, wb103, e103);
                @(posedge clk); #1;
                if (!(c.mem_wr && i == gnt_dly)) check_val({tag, ".hold"}, wb104, model_wb);
            end
            if (!c.mem_wr) begin
                for (int i = 0; i <= rv_dly; i++) begin
                    dmem_bus.gnt    = 1'($urandom_range(0, 1));
                    dmem_bus.rvalid = (i == rv_dly);
                    dmem_bus.rdata  = (i == rv_dly) ? rdata : $urandom;
                    #1;
                    check_val({tag, ".req_w"},   32'(dmem_bus.req), 32'd0);
                    check_val({tag, ".stall_r"}, 32'(stall), 32'(i != rv_dly));
                    @(posedge clk); #1;
                    if (i != rv_dly) check_val({tag, ".hold_r"}, wb104, model_wb);
                end
            end
        end else begin
            dmem_bus.gnt    = 1'($urandom_range(0, 1));
            dmem_bus.rvalid = 1'($urandom_range(0, 1));
            dmem_bus.rdata  = rdata;
            #1;
            check_val({tag, ".req0"},   32'(dmem_bus.req), 32'd0);
            check_val({tag, ".stall0"}, 32'(stall), 32'd0);
            check_val({tag, ".wb103"},  wb103, e103);
            @(posedge clk); #1;
        end
        check_val({tag, ".mis"}, 32'(misalign), 32'(mis));
        check_val({tag, ".wb104"}, wb104, e104);
        model_wb = e104;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0;
    endtask

    initial begin
        t_mem_ctrl rc;
        int        kind;
        n_cmp = 0; n_err = 0; model_wb = 32'h0;
        rst = 1'b1;
        ctrl = mk(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, WB_MEM);
        alu_out = 32'h100; wr_data = 32'h0; pc4 = 32'h0;
        dmem_bus.gnt = 1'b1; dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h0;
        #2;
        check_val("rst.req",   32'(dmem_bus.req), 32'd0);
        check_val("rst.stall", 32'(stall), 32'd0);
        check_val("rst.wb104", wb104, 32'd0);
        check_val("rst.mis",   32'(misalign), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op(mk(1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0, WB_ALU), 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, "sw");
        run_op(mk(1'b1, 1'b1, 1'b0, MEM_BYTE, 1'b0, WB_MEM), 32'h103, 32'h0, 32'h0, 0, 1, 32'h80FFFFFF, "lb");
        check_val("lb.const", wb104, 32'hFFFFFF80);
        run_op(mk(1'b1, 1'b1, 1'b0, MEM_BYTE, 1'b1, WB_MEM), 32'h103, 32'h0, 32'h0, 0, 1, 32'h80FFFFFF, "lbu");
        check_val("lbu.const", wb104, 32'h00000080);
        run_op(mk(1'b1, 1'b0, 1'b1, MEM_HALF, 1'b0, WB_ALU), 32'h202, 32'h1234, 32'h0, 3, 0, 32'h0, "sh");

        // Reset abandons an outstanding load; the late rvalid must be ignored.
        ctrl = mk(1'b1, 1'b1, 1'b0, MEM_BYTE, 1'b0, WB_MEM);
        alu_out = 32'h103; dmem_bus.gnt = 1'b1; dmem_bus.rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_bus.gnt = 1'b0; #1;
        check_val("rstw.stall_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        ctrl = mk(1'b0, 1'b0, 1'b0, MEM_WORD, 1'b0, WB_ALU);
        alu_out = 32'h0; pc4 = 32'h0; wr_data = 32'h0; #1;
        check_val("rstw.stall", 32'(stall), 32'd0);
        check_val("rstw.wb104", wb104, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; model_wb = 32'h0;
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hFFFFFFFF; #1;
        check_val("rstw.req_sp",   32'(dmem_bus.req), 32'd0);
        check_val("rstw.stall_sp", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_val("rstw.wb_sp", wb104, 32'd0);
        dmem_bus.rvalid = 1'b0;
        run_op(mk(1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0, WB_ALU), 32'h300, 32'h5A5A5A5A, 32'h0, 0, 0, 32'h0, "post_rst");

        run_op(mk(1'b1, 1'b0, 1'b0, MEM_WORD, 1'b0, WB_PC4), 32'h1000, 32'h0, 32'h44, 0, 0, 32'h0, "jal");
        check_val("jal.const", wb104, 32'h44);
        run_op(mk(1'b1, 1'b1, 1'b0, MEM_WORD, 1'b0, WB_MEM), 32'h101, 32'h0, 32'h0, 0, 0, 32'hCAFEF00D, "lw_mis");
        run_op(mk(1'b1, 1'b1, 1'b1, MEM_WORD, 1'b0, WB_ALU), 32'h400, 32'h11223344, 32'h0, 1, 0, 32'h0, "rdwr");

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 4));
            rc = mk(1'b1, 1'b0, 1'b0, t_mem_size'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), WB_ALU);
            case (kind)
                0: begin rc.mem_wr = 1'b1; rc.mem_rd = 1'($urandom_range(0, 1)); end
                1: begin rc.mem_rd = 1'b1; rc.sel_wb = WB_MEM; end
                2: rc.sel_wb = WB_PC4;
                3: begin rc.valid = 1'b0; rc.mem_rd = 1'b1; rc.sel_wb = t_sel_wb'($urandom_range(0, 2)); end
                default: rc.sel_wb = WB_ALU;
            endcase
            run_op(rc, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
